// File: rtl/pu_riscv_ahb3_htif_uart.sv
// AHB3-Lite slave for the TOHOST / UART-TX IO window.
// Latches host-interface writes and serialises UART bytes through a TX FIFO
// and an 8N1 shifter. A UART write to a full FIFO is held with wait states.
module pu_riscv_ahb3_htif_uart #(
  parameter int XLEN       = 32,
  parameter int PLEN       = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 16
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic            uart_txd,
  output logic [XLEN-1:0] tohost_data,
  output logic            tohost_valid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [7:0]    OFF_TOHOST = 8'h00;
  localparam logic [7:0]    OFF_UART   = 8'h80;
  localparam logic [7:0]    OFF_STATUS = 8'h84;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  // Bus-side registered state
  logic       dp_valid, dp_write, err1, err2;
  logic [7:0] dp_off;

  // FIFO state
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        empty, full, push, pop;

  // Shifter state
  tx_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        txd, frame_done;

  logic       accept, a_err, uart_wr, th_wr, stall;
  logic [7:0] a_off;
  logic [XLEN-1:0] status;
  logic       unused_sig;

  assign unused_sig = ^{HBURST, HPROT, HMASTLOCK, HADDR[PLEN-1:8]};

  assign accept = HSEL & HREADY & HTRANS[1];
  assign a_off  = HADDR[7:0];
  assign a_err  = !(a_off == OFF_TOHOST || a_off == OFF_UART || a_off == OFF_STATUS)
                | (HSIZE > 3'd2)
                | (HWRITE & (a_off == OFF_STATUS));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign frame_done = (state == S_STOP) && (cnt == '0);
  assign pop        = !empty && ((state == S_IDLE) || frame_done);

  // A UART write to a full FIFO waits; it completes in the cycle the shifter
  // pops, so the push slot is freed and refilled on the same edge.
  assign uart_wr = dp_valid & dp_write & (dp_off == OFF_UART);
  assign th_wr   = dp_valid & dp_write & (dp_off == OFF_TOHOST);
  assign stall   = uart_wr & full & !pop;
  assign push    = uart_wr & (!full | pop);

  assign HREADYOUT = !err1 & !stall;
  assign HRESP     = err1 | err2;
  assign uart_txd  = txd;

  // Address-phase capture and two-cycle ERROR sequencing
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
      err1     <= 1'b0;
      err2     <= 1'b0;
    end else begin
      err1 <= accept & a_err;
      err2 <= err1;
      if (HREADY) begin
        dp_valid <= accept & !a_err;
        dp_write <= HWRITE;
        dp_off   <= a_off;
      end
    end
  end

  // Host-interface register and its one-cycle strobe
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      tohost_data  <= '0;
      tohost_valid <= 1'b0;
    end else begin
      tohost_valid <= th_wr;
      if (th_wr) tohost_data <= HWDATA;
    end
  end

  // FIFO storage (no reset needed, pointers define validity)
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= HWDATA[7:0];
  end

  // FIFO pointers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // 8N1 shifter; txd is registered and updated on each state transition
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      txd   <= 1'b1;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_START;
            txd   <= 1'b0;
            cnt   <= DIV_M1;
            shreg <= mem[rd_ptr[AW-1:0]];
          end
        end
        S_START: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else begin
            state <= S_DATA;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            bitn  <= '0;
            cnt   <= DIV_M1;
          end
        end
        S_DATA: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else if (bitn == 3'd7) begin
            state <= S_STOP;
            txd   <= 1'b1;
            cnt   <= DIV_M1;
          end else begin
            bitn  <= bitn + 3'd1;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            cnt   <= DIV_M1;
          end
        end
        S_STOP: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else if (!empty) begin
            state <= S_START;
            txd   <= 1'b0;
            cnt   <= DIV_M1;
            shreg <= mem[rd_ptr[AW-1:0]];
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data decoded from the registered data-phase offset
  always_comb begin
    status        = '0;
    status[10:0]  = {8'(level), (state != S_IDLE), full, empty};
    HRDATA        = '0;
    if (dp_valid && !dp_write) begin
      case (dp_off)
        OFF_TOHOST: HRDATA = tohost_data;
        OFF_STATUS: HRDATA = status;
        default:    HRDATA = '0;
      endcase
    end
  end

endmodule
